// File: rtl/qsort_stream_dma.sv
// Memory-to-accelerator-to-memory DMA: streams len words from src into a sort
// accelerator, waits for it to finish, then writes its output stream to dst.
module qsort_stream_dma #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pLEN_WIDTH  = 6
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [pADDR_WIDTH-1:0] src_base,
    input  logic [pADDR_WIDTH-1:0] dst_base,
    input  logic [pLEN_WIDTH-1:0]  len,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_req,
    output logic [pADDR_WIDTH-1:0] rd_addr,
    input  logic                   rd_ack,
    input  logic [pDATA_WIDTH-1:0] rd_data,
    output logic                   wr_req,
    output logic [pADDR_WIDTH-1:0] wr_addr,
    output logic [pDATA_WIDTH-1:0] wr_data,
    input  logic                   wr_ack,
    output logic                   acc_start,
    input  logic                   acc_done,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    input  logic                   m_tready,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    output logic                   s_tready
);

    typedef enum logic [2:0] {S_IDLE, S_KICK, S_FEED, S_WAIT, S_DRAIN, S_FIN} state_t;

    state_t                 r_state, w_next;
    logic [pADDR_WIDTH-1:0] r_src, r_dst;
    logic [pLEN_WIDTH-1:0]  r_len, r_rd_cnt, r_tx_cnt, r_rx_cnt, r_wr_cnt;
    logic [pDATA_WIDTH-1:0] r_fbuf, r_wbuf;
    logic                   r_ffull, r_wfull;
    logic                   w_go, w_rd_fire, w_tx_fire, w_rx_fire, w_wr_fire;

    assign w_go      = (r_state == S_IDLE) && start;
    assign w_rd_fire = rd_req & rd_ack;
    assign w_tx_fire = m_tvalid & m_tready;
    assign w_rx_fire = s_tvalid & s_tready;
    assign w_wr_fire = wr_req & wr_ack;

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign acc_start = (r_state == S_KICK);
    assign rd_req    = (r_state == S_FEED) && !r_ffull && (r_rd_cnt < r_len);
    assign m_tvalid  = r_ffull;
    assign m_tdata   = r_fbuf;
    assign s_tready  = (r_state == S_DRAIN) && !r_wfull && (r_rx_cnt < r_len);
    assign wr_req    = r_wfull;
    assign wr_data   = r_wbuf;
    // Byte offsets wrap naturally through the truncating cast.
    assign rd_addr   = r_src + pADDR_WIDTH'({r_rd_cnt, 2'b00});
    assign wr_addr   = r_dst + pADDR_WIDTH'({r_wr_cnt, 2'b00});

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (len == '0) ? S_FIN : S_KICK;
            S_KICK:  w_next = S_FEED;
            S_FEED:  if (r_tx_cnt == r_len) w_next = S_WAIT;
            S_WAIT:  if (acc_done) w_next = S_DRAIN;
            S_DRAIN: if (r_wr_cnt == r_len) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_rd_cnt <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_wr_cnt <= '0;
            r_fbuf   <= '0;
            r_wbuf   <= '0;
            r_ffull  <= 1'b0;
            r_wfull  <= 1'b0;
        end else if (w_go) begin
            r_src    <= src_base;
            r_dst    <= dst_base;
            r_len    <= len;
            r_rd_cnt <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_wr_cnt <= '0;
            r_ffull  <= 1'b0;
            r_wfull  <= 1'b0;
        end else begin
            // Fill and empty of each buffer are mutually exclusive: req/ready gate on empty.
            if (w_rd_fire) begin
                r_fbuf   <= rd_data;
                r_ffull  <= 1'b1;
                r_rd_cnt <= r_rd_cnt + pLEN_WIDTH'(1);
            end
            if (w_tx_fire) begin
                r_ffull  <= 1'b0;
                r_tx_cnt <= r_tx_cnt + pLEN_WIDTH'(1);
            end
            if (w_rx_fire) begin
                r_wbuf   <= s_tdata;
                r_wfull  <= 1'b1;
                r_rx_cnt <= r_rx_cnt + pLEN_WIDTH'(1);
            end
            if (w_wr_fire) begin
                r_wfull  <= 1'b0;
                r_wr_cnt <= r_wr_cnt + pLEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_qsort_stream_dma.sv
// Directed bench for qsort_stream_dma with memory, sort-accelerator model and
// scoreboards for read addresses, fed words and written address/data pairs.
module tb_qsort_stream_dma;

    localparam int A = 12;
    localparam int D = 32;
    localparam int L = 6;

    typedef logic [D-1:0] wbuf_t [64];

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          start;
    logic [A-1:0]  src_base, dst_base;
    logic [L-1:0]  len;
    logic          busy, done, rd_req, rd_ack, wr_req, wr_ack, acc_start, acc_done;
    logic [A-1:0]  rd_addr, wr_addr;
    logic [D-1:0]  rd_data, wr_data, m_tdata, s_tdata;
    logic          m_tvalid, m_tready, s_tvalid, s_tready;

    always #5 axis_clk = ~axis_clk;

    qsort_stream_dma #(.pADDR_WIDTH(A), .pDATA_WIDTH(D), .pLEN_WIDTH(L)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .acc_start(acc_start), .acc_done(acc_done),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wbuf_t sort_words(input wbuf_t a, input int n);
        wbuf_t   r;
        logic [D-1:0] t;
        r = a;
        for (int i = 1; i < n; i++) begin
            t = r[i];
            for (int j = i; j > 0; j--) begin
                if (r[j-1] > t) begin
                    r[j]   = r[j-1];
                    r[j-1] = t;
                end
            end
        end
        return r;
    endfunction

    // Memory: immediate reads, writes acknowledged after wr_delay wait cycles.
    logic [D-1:0] mem [0:1023];
    int wr_delay = 0;
    int wr_wait;
    assign rd_ack  = rd_req;
    assign rd_data = mem[rd_addr[11:2]];
    assign wr_ack  = wr_req && (wr_wait >= wr_delay);
    always @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n)           wr_wait <= 0;
        else if (wr_req && !wr_ack) wr_wait <= wr_wait + 1;
        else                       wr_wait <= 0;
    end

    // Accelerator: collect cur_len words, sort ascending, stream them back.
    int    cur_len = 0;
    wbuf_t acc_buf;
    int    acc_rx, acc_tx, stall_cnt;
    logic  acc_done_r;
    bit    stall_en = 1'b0;
    assign acc_done = acc_done_r;
    assign m_tready = !(stall_en && acc_rx == 4 && stall_cnt < 3);
    assign s_tvalid = acc_done_r && (acc_tx < cur_len);
    assign s_tdata  = acc_buf[acc_tx[5:0]];
    always @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            acc_rx <= 0; acc_tx <= 0; acc_done_r <= 1'b0; stall_cnt <= 0;
        end else if (acc_start) begin
            acc_rx <= 0; acc_tx <= 0; acc_done_r <= 1'b0; stall_cnt <= 0;
        end else begin
            if (m_tvalid && m_tready) begin
                acc_buf[acc_rx[5:0]] <= m_tdata;
                acc_rx <= acc_rx + 1;
            end
            if (m_tvalid && !m_tready) stall_cnt <= stall_cnt + 1;
            if (!acc_done_r && cur_len > 0 && acc_rx == cur_len) begin
                acc_buf    <= sort_words(acc_buf, cur_len);
                acc_done_r <= 1'b1;
            end
            if (s_tvalid && s_tready) acc_tx <= acc_tx + 1;
        end
    end

    // Scoreboards and event counters.
    logic [A-1:0]   rd_q[$];
    logic [D-1:0]   feed_q[$];
    logic [A+D-1:0] wr_q[$];
    int done_cnt, rd_cyc, acc_cnt, wr_cyc, n_tx, n_wr, hold_cnt;

    always @(negedge axis_clk) begin
        if (done)      done_cnt++;
        if (rd_req)    rd_cyc++;
        if (acc_start) acc_cnt++;
        if (wr_req)    wr_cyc++;
        if (rd_req && rd_ack) begin
            if (rd_q.size() == 0) chk("rd_extra", 64'(rd_addr), 64'hdead);
            else                  chk("rd_addr", 64'(rd_addr), 64'(rd_q.pop_front()));
        end
        if (m_tvalid && !m_tready) begin
            hold_cnt++;
            if (feed_q.size() == 0) chk("hold_extra", 64'(m_tdata), 64'hdead);
            else                    chk("m_hold", 64'(m_tdata), 64'(feed_q[0]));
        end
        if (m_tvalid && m_tready) begin
            n_tx++;
            if (feed_q.size() == 0) chk("feed_extra", 64'(m_tdata), 64'hdead);
            else                    chk("feed_data", 64'(m_tdata), 64'(feed_q.pop_front()));
        end
        if (wr_req && wr_delay > 0) chk("s_tready_wr_pend", 64'(s_tready), 64'd0);
        if (wr_req && wr_ack) begin
            n_wr++;
            if (wr_q.size() == 0) chk("wr_extra", 64'({wr_addr, wr_data}), 64'hdead);
            else                  chk("wr_addr_data", 64'({wr_addr, wr_data}), 64'(wr_q.pop_front()));
        end
    end

    task automatic start_xfer(input logic [A-1:0] s, input logic [A-1:0] d, input int n);
        wbuf_t        w;
        logic [A-1:0] a;
        done_cnt = 0; rd_cyc = 0; acc_cnt = 0; wr_cyc = 0; n_tx = 0; n_wr = 0; hold_cnt = 0;
        for (int i = 0; i < n; i++) begin
            a = s + A'(4 * i);
            rd_q.push_back(a);
            feed_q.push_back(mem[a[11:2]]);
            w[i] = mem[a[11:2]];
        end
        w = sort_words(w, n);
        for (int i = 0; i < n; i++) wr_q.push_back({d + A'(4 * i), w[i]});
        cur_len = n;
        @(negedge axis_clk);
        start = 1'b1; src_base = s; dst_base = d; len = L'(n);
        @(negedge axis_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 1;
        while (!done && lat < budget) begin
            @(negedge axis_clk);
            lat++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic finish_xfer(input string tag, input int n);
        int lat;
        wait_done(2000, lat);
        repeat (2) @(negedge axis_clk);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_acc_start_cnt"}, 64'(acc_cnt), 64'd1);
        chk({tag, "_tx_cnt"}, 64'(n_tx), 64'(n));
        chk({tag, "_wr_cnt"}, 64'(n_wr), 64'(n));
        chk({tag, "_queues_left"}, 64'(rd_q.size() + feed_q.size() + wr_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({busy, done, rd_req, wr_req, acc_start, m_tvalid, s_tready}), 64'd0);
        chk({tag, "_addr"}, 64'({rd_addr, wr_addr}), 64'd0);
        chk({tag, "_data"}, 64'({wr_data, m_tdata}), 64'd0);
    endtask

    initial begin
        int lat;
        start = 1'b0; src_base = '0; dst_base = '0; len = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hc000_0000 + i;
        for (int i = 0; i < 10; i++) mem[(12'h100 >> 2) + i] = 32'(9 - i);
        mem[1023] = 32'haaaa;
        mem[0]    = 32'h5555;

        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

        // Basic 10-word sort, immediate acks.
        start_xfer(12'h100, 12'h200, 10);
        finish_xfer("basic", 10);

        // Zero length: straight to FIN.
        start_xfer(12'h100, 12'h200, 0);
        wait_done(10, lat);
        chk("len0_latency_le2", 64'(lat <= 2), 64'd1);
        repeat (2) @(negedge axis_clk);
        chk("len0_activity", 64'(rd_cyc + acc_cnt + wr_cyc), 64'd0);
        chk("len0_done_cnt", 64'(done_cnt), 64'd1);
        chk("len0_busy_after", 64'(busy), 64'd0);

        // Back-pressure on word 4.
        stall_en = 1'b1;
        start_xfer(12'h100, 12'h200, 10);
        finish_xfer("stall", 10);
        chk("stall_hold_cycles", 64'(hold_cnt), 64'd3);
        stall_en = 1'b0;

        // Slow write acknowledge.
        wr_delay = 5;
        start_xfer(12'h100, 12'h280, 10);
        finish_xfer("slow_wr", 10);
        wr_delay = 0;

        // Source address wrap.
        start_xfer(12'hffc, 12'h300, 2);
        finish_xfer("wrap", 2);

        // Reset in the middle of the drain phase.
        start_xfer(12'h100, 12'h200, 10);
        lat = 0;
        while (n_wr < 4 && lat < 2000) begin
            @(negedge axis_clk);
            lat++;
        end
        chk("mid_reset_reached_4", 64'(n_wr >= 4), 64'd1);
        @(posedge axis_clk);
        #2 axis_rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (3) @(negedge axis_clk);
        chk("mid_reset_no_done", 64'(done_cnt), 64'd0);
        rd_q.delete(); feed_q.delete(); wr_q.delete();
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        start_xfer(12'h100, 12'h200, 10);
        finish_xfer("after_reset", 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qsort_stream_dma.md
QSORT_STREAM_DMA -- requirements
Module: qsort_stream_dma

Interface
REQ-001 Parameter pADDR_WIDTH, default 12, memory byte-address width.
REQ-002 Parameter pDATA_WIDTH, default 32, data word width.
REQ-003 Parameter pLEN_WIDTH, default 6, transfer-length counter width.
REQ-004 axis_clk  in  1  clock; all logic on rising edge.
REQ-005 axis_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  begin transfer; sampled only in IDLE.
REQ-007 src_base, dst_base  in  pADDR_WIDTH  source and destination byte addresses.
REQ-008 len  in  pLEN_WIDTH  word count.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rd_req  out  1; rd_addr  out  pADDR_WIDTH; rd_ack  in  1; rd_data  in  pDATA_WIDTH: memory read port.
REQ-012 wr_req  out  1; wr_addr  out  pADDR_WIDTH; wr_data  out  pDATA_WIDTH; wr_ack  in  1: memory write port.
REQ-013 acc_start  out  1  accelerator start pulse; acc_done  in  1  accelerator sorted-ready level.
REQ-014 m_tvalid  out  1; m_tdata  out  pDATA_WIDTH; m_tready  in  1: AXI-Stream master into accelerator.
REQ-015 s_tvalid  in  1; s_tdata  in  pDATA_WIDTH; s_tready  out  1: AXI-Stream slave from accelerator.

Function
REQ-016 FSM states SHALL be IDLE, KICK, FEED, WAIT, DRAIN, FIN.
REQ-017 IDLE: on start=1, latch src_base, dst_base and len, and clear the rd/tx/rx/wr counters; go to FIN if len=0, else KICK.
REQ-018 start SHALL be ignored outside IDLE; latched operands SHALL NOT change until the next IDLE.
REQ-019 KICK: acc_start=1 for exactly one cycle, then FEED.
REQ-020 FEED: one-word feed buffer; rd_req asserted when buffer empty and rd count < len, held until rd_ack.
REQ-021 rd_addr SHALL equal src_latch + 4*rd count, modulo 2^pADDR_WIDTH (wrap, no error).
REQ-022 On rd_ack: capture rd_data into buffer, increment rd count, drop rd_req the next cycle.
REQ-023 m_tvalid SHALL equal buffer-full; m_tdata SHALL equal the buffer and stay stable while m_tvalid=1 and m_tready=0.
REQ-024 On m_tvalid & m_tready: buffer empties and tx count increments; rd_ack and handshake in the same cycle on an empty buffer are impossible by construction.
REQ-025 FEED to WAIT when tx count = len.
REQ-026 WAIT: go to DRAIN on the first cycle acc_done=1; no timeout.
REQ-027 DRAIN: s_tready=1 when the write buffer is empty and rx count < len, else 0; s_tready=0 in all other states.
REQ-028 On s_tvalid & s_tready: capture s_tdata into the write buffer and increment rx count; wr_req asserted from the next cycle until wr_ack.
REQ-029 wr_addr SHALL equal dst_latch + 4*wr count, modulo 2^pADDR_WIDTH; wr_data SHALL equal the write buffer.
REQ-030 On wr_ack: increment wr count and empty the buffer; s_tready may reassert the next cycle.
REQ-031 DRAIN to FIN when wr count = len.
REQ-032 FIN: done=1 for one cycle, then IDLE; a start in the FIN cycle SHALL be ignored.
REQ-033 Words SHALL be written in the order received; no reordering, no data alteration.
REQ-034 rd_req, wr_req, m_tvalid, s_tready and acc_start SHALL be 0 in IDLE.
REQ-035 rd_ack or wr_ack while the matching req=0 SHALL be ignored.

Reset
REQ-036 Asynchronous assert: state=IDLE, all counters 0, all buffers empty; busy, done, rd_req, wr_req, acc_start, m_tvalid, s_tready = 0; addresses and data outputs = 0.
REQ-037 Reset mid-transfer SHALL abandon the transfer with no done pulse; the first start after deassert runs a fresh transfer.

Verification
REQ-038 len=10, src=0x100, dst=0x200, memory {9..0}, ideal accelerator model, acks immediate -> reads 0x100..0x124, one acc_start, writes {0..9} to 0x200..0x224, single done, busy low after.
REQ-039 len=0 with start -> no rd_req, acc_start or wr_req; done pulses 2 cycles after start.
REQ-040 m_tready low 3 cycles on word 4 -> m_tdata holds the word-4 value, no duplicated or dropped word, tx count ends at 10.
REQ-041 wr_ack delayed 5 cycles per word -> s_tready stays low while wr_req pending; all 10 words written in order.
REQ-042 src=0xFFC, len=2 -> rd_addr 0xFFC then 0x000.
REQ-043 Reset asserted during DRAIN after 4 writes -> outputs go to reset values immediately, no done; a new start completes a full 10-word transfer.
